bin2bcd_seq: RTL
================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: IN_W, 14, binary input width; the block supports only 14.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  conversion request, sampled on the clock edge.
REQ-005 Port: bin  input  IN_W  unsigned binary value, sampled when start is accepted.
REQ-006 Port: busy  output  1  high while a conversion is in progress.
REQ-007 Port: done  output  1  one-cycle pulse when the result registers update.
REQ-008 Port: bcd  output  16  four BCD digits, [15:12]=thousands … [3:0]=units; feeds the 4-digit hex mux stage.
REQ-009 Port: ovf  output  1  the last accepted bin exceeded 9999.
REQ-010 Port: blank  output  4  per-digit leading-zero blank mask, bit i matches digit i.

Function
REQ-011 FSM states: IDLE, SHIFT.
- IDLE: start=1 at an edge accepts the request, captures bin into the shift register, clears the iteration count, sets busy=1 and moves to SHIFT.
REQ-012 SHIFT performs one double-dabble iteration per clock.
- First, each 4-bit BCD nibble ≥5 gets +3.
- Then the combined {bcd_work, bin_work} shifts left by 1.
REQ-013 Iteration 14 (count=13) completes the conversion:
- bcd and ovf outputs update at that edge.
- done=1 for exactly one cycle.
- busy returns to 0 and the FSM returns to IDLE.
REQ-014 Latency is fixed: start accepted at edge E gives done high in the cycle following edge E+14. It is independent of the value, including overflow.
REQ-015 start while busy=1 is ignored; bin changes while busy have no effect.
REQ-016 start=1 in the cycle where done=1 is accepted, since the FSM is in IDLE; back-to-back throughput is one result per 15 cycles.
REQ-017 Overflow is judged at capture: bin>9999 sets an internal flag.
- On completion: bcd=16'hFFFF and ovf=1.
- Otherwise: bcd is the converted value and ovf=0.
REQ-018 bcd, ovf and blank hold their values between completions; intermediate iterations never appear on bcd.
REQ-019 done is a registered signal; busy and done are never high in the same cycle.
REQ-020 Arithmetic: the working register is 16+IN_W=30 bits, and nibble corrections never carry between digits.

Reset
REQ-021 When rst_n=0, the block SHALL immediately force:
- FSM=IDLE, busy=0, done=0
- bcd=16'h0000, ovf=0
- internal work registers and count cleared
REQ-022 At reset, blank SHALL be 4'b1110 when BIN2BCD_BLANK_EN is defined and 4'b0000 otherwise.
REQ-023 Reset asserted mid-conversion aborts the conversion: no done pulse, and bcd stays 16'h0000 after release.
REQ-024 The first accepted start after rst_n rises is the first clock edge with rst_n=1 and start=1.

Configuration
REQ-025 The macro BIN2BCD_BLANK_EN selects leading-zero blanking.
- Defined: blank updates with bcd at completion. Bit i=1 when digit i and every more-significant digit are 0, for i=3..1. Bit 0 is always 0. blank=4'b0000 when ovf=1.
- Undefined: blank is constantly 4'b0000 and no blanking logic is present.

Verification
REQ-026 Case: rst_n low then high, start one cycle with bin=1234 -> busy for 14 cycles, then done pulse with bcd=16'h1234, ovf=0, blank=4'b0000.
REQ-027 Case: bin=9999, then bin=0 -> bcd=16'h9999; then bcd=16'h0000 with blank=4'b1110 (macro defined) or 4'b0000 (undefined).
REQ-028 Case: bin=10000 and bin=16383 -> each gives bcd=16'hFFFF, ovf=1, blank=4'b0000, done at the same 14-cycle latency.
REQ-029 Case: start held high continuously with bin=42 -> one done every 15 cycles; pulses of start during busy create no extra done.
REQ-030 Case: start with bin=777, rst_n pulsed low at iteration 7 -> no done, bcd=16'h0000; a new start with bin=56 -> bcd=16'h0056, blank=4'b1100 (macro defined).

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one iteration per clock).
// Define BIN2BCD_BLANK_EN to enable the leading-zero blank mask on the blank output.
module bin2bcd_seq #(
    parameter int IN_W = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd,
    output logic            ovf,
    output logic [3:0]      blank
);

    localparam int WORK_W = 16 + IN_W;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic                ovf_flag_q, ovf_flag_d;
    logic [15:0]         bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic [WORK_W-1:0]   corr;
    logic [WORK_W-1:0]   shifted;

    // Each nibble is corrected in isolation; any 4-bit wrap is discarded rather than carried.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_corr
            logic [3:0] nib;
            assign nib = work_q[IN_W + 4*gi +: 4];
            assign corr[IN_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate
    assign corr[IN_W-1:0] = work_q[IN_W-1:0];
    assign shifted        = {corr[WORK_W-2:0], 1'b0};

`ifdef BIN2BCD_BLANK_EN
    logic [3:0] blank_q, blank_d;
    logic       z3, z2, z1;
    assign z3 = (shifted[WORK_W-1 -: 4] == 4'd0);
    assign z2 = (shifted[WORK_W-5 -: 4] == 4'd0);
    assign z1 = (shifted[WORK_W-9 -: 4] == 4'd0);
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        work_d     = work_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
`ifdef BIN2BCD_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d     = {16'h0000, bin};
                    count_d    = 4'd0;
                    ovf_flag_d = (bin > IN_W'(9999));
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = shifted;
                count_d = count_q + 4'd1;
                if (count_q == 4'(IN_W - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_flag_q;
                    bcd_d   = ovf_flag_q ? 16'hFFFF : shifted[WORK_W-1 -: 16];
`ifdef BIN2BCD_BLANK_EN
                    blank_d = ovf_flag_q ? 4'b0000 : {z3, z3 & z2, z3 & z2 & z1, 1'b0};
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            work_q     <= '0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            work_q     <= work_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank_q <= 4'b1110;
        else        blank_q <= blank_d;
    end
    assign blank = blank_q;
`else
    assign blank = 4'b0000;
`endif

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule
